imem_uart_loader: RTL and testbench

// - Boot controller for the CPU instruction memory. On request it holds the CPU in reset.
// - It receives a framed program image from the UART receiver and writes 32-bit words into instruction RAM.
// - It checks the frame, then releases the CPU so it runs from PC 0.
// - Sits between uart_rx, the instruction RAM write port and the CPU reset input.

---
 rtl/imem_uart_loader_pkg.sv | 28 ++
 rtl/imem_uart_loader_timeout.sv | 33 +++
 rtl/imem_uart_loader.sv | 200 ++++++++++++++++++++
 tb/tb_imem_uart_loader.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_uart_loader_pkg.sv
// Shared definitions for the instruction-memory UART boot loader:
// FSM state encodings, frame field widths and the default sync marker.
package imem_uart_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SYNC   = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_LEN_LO = 3'd3,
    ST_DATA   = 3'd4,
    ST_CSUM   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERROR  = 3'd7
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  localparam int BYTE_W = 8;   // one UART byte
  localparam int LEN_W  = 16;  // word count field (LEN_HI:LEN_LO)
  localparam int WORD_W = 32;  // instruction word
  localparam int ADDR_W = 32;  // byte address into instruction RAM

  // States in which a stalled byte stream is treated as a broken frame.
  function automatic logic is_timed(input state_t s);
    return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/imem_uart_loader_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled, restarts on clear,
// and flags expiry on the cycle the count would reach TIMEOUT_CYC.
module imem_uart_loader_timeout #(
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_last;

  assign w_at_last = (r_cnt == LAST_CNT);
  // The count saturates at LAST_CNT; expiry is suppressed on a clearing cycle
  // so a byte arriving exactly at the limit still counts as on time.
  assign o_expired = i_enable && !i_clear && w_at_last;

  // Idle-cycle counter, cleared by reset, by any byte, or while not supervising.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !w_at_last) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Boot controller: holds the CPU in reset, parses a framed program image from
// the UART byte stream, writes it word by word into instruction RAM, verifies
// the XOR checksum and then releases the CPU to run from address 0.
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int                DEPTH       = 256,
  parameter int                TIMEOUT_CYC = 1000000,
  parameter logic [BYTE_W-1:0] SYNC_BYTE   = SYNC_BYTE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              boot_req,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_reset,
  output logic              load_done,
  output logic              load_error,
  output logic [LEN_W-1:0]  words_rx
);

  state_t              r_state,      w_state_next;
  logic [BYTE_W-1:0]   r_len_hi,     w_len_hi_next;
  logic [LEN_W-1:0]    r_len,        w_len_next;
  logic [WORD_W-1:0]   r_word,       w_word_next;
  logic [1:0]          r_byte_cnt,   w_byte_cnt_next;
  logic [BYTE_W-1:0]   r_csum,       w_csum_next;
  logic                r_we,         w_we_next;
  logic [ADDR_W-1:0]   r_addr,       w_addr_next;
  logic [WORD_W-1:0]   r_wdata,      w_wdata_next;
  logic                r_cpu_reset,  w_cpu_reset_next;
  logic                r_done,       w_done_next;
  logic                r_error,      w_error_next;
  logic [LEN_W-1:0]    r_words,      w_words_next;

  logic                w_timed;
  logic                w_expired;
  logic [LEN_W-1:0]    w_len_rx;
  logic [WORD_W-1:0]   w_word_shift;

  assign w_timed      = is_timed(r_state);
  assign w_len_rx     = {r_len_hi, rx_data};
  assign w_word_shift = {r_word[WORD_W-BYTE_W-1:0], rx_data};

  imem_uart_loader_timeout #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (rx_valid || boot_req || !w_timed),
    .i_enable  (w_timed),
    .o_expired (w_expired)
  );

  // Next-state, datapath and output decisions; boot_req overrides everything,
  // including a byte strobed in the same cycle.
  always_comb begin
    w_state_next     = r_state;
    w_len_hi_next    = r_len_hi;
    w_len_next       = r_len;
    w_word_next      = r_word;
    w_byte_cnt_next  = r_byte_cnt;
    w_csum_next      = r_csum;
    w_we_next        = 1'b0;
    w_addr_next      = r_addr;
    w_wdata_next     = r_wdata;
    w_cpu_reset_next = r_cpu_reset;
    w_done_next      = r_done;
    w_error_next     = r_error;
    w_words_next     = r_words;

    if (boot_req) begin
      w_state_next     = ST_SYNC;
      w_cpu_reset_next = 1'b1;
      w_done_next      = 1'b0;
      w_error_next     = 1'b0;
      w_words_next     = '0;
      w_byte_cnt_next  = '0;
      w_csum_next      = '0;
      w_word_next      = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
        end
        ST_SYNC: begin
          if (rx_valid && (rx_data == SYNC_BYTE)) begin
            w_state_next = ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (rx_valid) begin
            w_len_hi_next = rx_data;
            w_state_next  = ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (rx_valid) begin
            w_len_next = w_len_rx;
            if (w_len_rx > LEN_W'(DEPTH)) begin
              w_state_next = ST_ERROR;
              w_error_next = 1'b1;
            end else if (w_len_rx == '0) begin
              // Empty image: the checksum of zero bytes is 8'h00, already held.
              w_state_next = ST_CSUM;
            end else begin
              w_state_next = ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (rx_valid) begin
            w_word_next     = w_word_shift;
            w_csum_next     = r_csum ^ rx_data;
            w_byte_cnt_next = r_byte_cnt + 2'd1;
            if (r_byte_cnt == 2'd3) begin
              w_we_next    = 1'b1;
              w_addr_next  = {{(ADDR_W-LEN_W-2){1'b0}}, r_words, 2'b00};
              w_wdata_next = w_word_shift;
              w_words_next = r_words + LEN_W'(1);
              if (r_words == (r_len - LEN_W'(1))) begin
                w_state_next = ST_CSUM;
              end
            end
          end
        end
        ST_CSUM: begin
          if (rx_valid) begin
            if (rx_data == r_csum) begin
              w_state_next = ST_DONE;
              w_done_next  = 1'b1;
            end else begin
              w_state_next = ST_ERROR;
              w_error_next = 1'b1;
            end
          end
        end
        ST_DONE: begin
          // Release the core one cycle after the image is verified.
          w_cpu_reset_next = 1'b0;
        end
        ST_ERROR: begin
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase

      // Expiry only fires in supervised states on a cycle without a byte.
      if (w_expired) begin
        w_state_next = ST_ERROR;
        w_error_next = 1'b1;
      end
    end
  end

  // State and datapath registers; reset lets the CPU run whatever is resident.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_len_hi    <= '0;
      r_len       <= '0;
      r_word      <= '0;
      r_byte_cnt  <= '0;
      r_csum      <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_cpu_reset <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_words     <= '0;
    end else begin
      r_state     <= w_state_next;
      r_len_hi    <= w_len_hi_next;
      r_len       <= w_len_next;
      r_word      <= w_word_next;
      r_byte_cnt  <= w_byte_cnt_next;
      r_csum      <= w_csum_next;
      r_we        <= w_we_next;
      r_addr      <= w_addr_next;
      r_wdata     <= w_wdata_next;
      r_cpu_reset <= w_cpu_reset_next;
      r_done      <= w_done_next;
      r_error     <= w_error_next;
      r_words     <= w_words_next;
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign cpu_reset  = r_cpu_reset;
  assign load_done  = r_done;
  assign load_error = r_error;
  assign words_rx   = r_words;

endmodule

// File: tb/tb_imem_uart_loader.sv
// Table-driven bench for the UART boot loader: each table row is one clock of
// stimulus plus the outputs expected right after that clock edge.
module tb_imem_uart_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        boot_req = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        cpu_reset;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_rx;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  imem_uart_loader #(
    .DEPTH       (256),
    .TIMEOUT_CYC (50),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .boot_req   (boot_req),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_reset  (cpu_reset),
    .load_done  (load_done),
    .load_error (load_error),
    .words_rx   (words_rx)
  );

  typedef struct {
    logic        rst;
    logic        boot;
    logic        valid;
    logic [7:0]  data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        cr;
    logic        done;
    logic        err;
    logic [15:0] words;
  } vec_t;

  vec_t tbl[$];

  // Expected output levels after the row being added.
  logic [31:0] e_addr, e_wdata;
  logic        e_cr, e_done, e_err;
  logic [15:0] e_words;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add_row(input logic rst, input logic b, input logic v, input logic [7:0] d, input logic we);
    vec_t t;
    t.rst = rst; t.boot = b; t.valid = v; t.data = d; t.we = we;
    t.addr = e_addr; t.wdata = e_wdata; t.cr = e_cr; t.done = e_done;
    t.err = e_err; t.words = e_words;
    tbl.push_back(t);
  endtask

  task automatic row(input logic b, input logic v, input logic [7:0] d, input logic we);
    add_row(1'b0, b, v, d, we);
  endtask

  task automatic byte_row(input logic [7:0] d);
    add_row(1'b0, 1'b0, 1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) add_row(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  // Four data bytes MSB first; the write lands right after the fourth byte at 4*index.
  task automatic word_rows(input logic [31:0] w);
    for (int b = 0; b < 3; b++) byte_row(w[31-8*b -: 8]);
    e_addr  = {14'd0, e_words, 2'b00};
    e_wdata = w;
    e_words = e_words + 16'd1;
    add_row(1'b0, 1'b0, 1'b1, w[7:0], 1'b1);
  endtask

  task automatic drive(input logic rst, input logic b, input logic v, input logic [7:0] d);
    @(negedge clk);
    reset = rst; boot_req = b; rx_valid = v; rx_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_we", 0, {31'd0, imem_we}, 32'd0);
    check("rst_addr", 0, imem_addr, 32'd0);
    check("rst_wdata", 0, imem_wdata, 32'd0);
    check("rst_cpu_reset", 0, {31'd0, cpu_reset}, 32'd0);
    check("rst_done", 0, {31'd0, load_done}, 32'd0);
    check("rst_error", 0, {31'd0, load_error}, 32'd0);
    check("rst_words", 0, {16'd0, words_rx}, 32'd0);

    e_addr = 32'd0; e_wdata = 32'd0; e_cr = 1'b0; e_done = 1'b0; e_err = 1'b0; e_words = 16'd0;

    // 1: single word, noise before sync, bytes after DONE ignored
    e_cr = 1'b1; row(1, 0, 8'h00, 0);
    byte_row(8'h11); byte_row(8'h22);
    byte_row(8'hA5); byte_row(8'h00); byte_row(8'h01);
    word_rows(32'h200800C0);
    idle(1);
    e_done = 1'b1; byte_row(8'hE8);
    e_cr = 1'b0; idle(1);
    byte_row(8'h55); idle(1);

    // 2: three words, checksum CC
    e_cr = 1'b1; e_done = 1'b0; e_words = 16'd0; row(1, 0, 8'h00, 0);
    byte_row(8'hA5); byte_row(8'h00); byte_row(8'h03);
    word_rows(32'h11223344); word_rows(32'h55667788); word_rows(32'h99AABBCC);
    e_done = 1'b1; byte_row(8'hCC);
    e_cr = 1'b0; idle(1);

    // 3: same frame, checksum flipped
    e_cr = 1'b1; e_done = 1'b0; e_words = 16'd0; row(1, 0, 8'h00, 0);
    byte_row(8'hA5); byte_row(8'h00); byte_row(8'h03);
    word_rows(32'h11223344); word_rows(32'h55667788); word_rows(32'h99AABBCC);
    e_err = 1'b1; byte_row(8'h33);
    idle(2);

    // 4a: LEN 0x0101 exceeds depth
    e_err = 1'b0; e_words = 16'd0; row(1, 0, 8'h00, 0);
    byte_row(8'hA5); byte_row(8'h01);
    e_err = 1'b1; byte_row(8'h01);
    idle(2);

    // 4b: LEN 0 with checksum 00
    e_err = 1'b0; row(1, 0, 8'h00, 0);
    byte_row(8'hA5); byte_row(8'h00); byte_row(8'h00);
    e_done = 1'b1; byte_row(8'h00);
    e_cr = 1'b0; idle(1);

    // 5: no timeout while hunting for sync, then a stalled data stream
    e_cr = 1'b1; e_done = 1'b0; row(1, 0, 8'h00, 0);
    idle(60);
    byte_row(8'hA5); byte_row(8'h00); byte_row(8'h01);
    byte_row(8'hDE); byte_row(8'hAD);
    idle(49);
    e_err = 1'b1; idle(1);
    idle(1);

    // 6: boot_req mid-word with a coincident byte 3, then with a coincident sync byte
    e_err = 1'b0; row(1, 0, 8'h00, 0);
    byte_row(8'hA5); byte_row(8'h00); byte_row(8'h01);
    byte_row(8'h12); byte_row(8'h34); byte_row(8'h56);
    row(1, 1, 8'h78, 0);
    row(1, 1, 8'hA5, 0);
    byte_row(8'hA5); byte_row(8'h00); byte_row(8'h01);
    word_rows(32'hAABBCCDD);
    e_done = 1'b1; byte_row(8'h00);
    e_cr = 1'b0; idle(1);

    // 6: reset mid-load returns to IDLE with the CPU released
    e_cr = 1'b1; e_done = 1'b0; e_words = 16'd0; row(1, 0, 8'h00, 0);
    byte_row(8'hA5); byte_row(8'h00); byte_row(8'h02);
    word_rows(32'h01020304);
    byte_row(8'h05);
    e_addr = 32'd0; e_wdata = 32'd0; e_cr = 1'b0; e_words = 16'd0;
    add_row(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    byte_row(8'hA5); byte_row(8'h00); byte_row(8'h01);
    byte_row(8'h11); byte_row(8'h22); byte_row(8'h33); byte_row(8'h44);
    idle(1);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].boot, tbl[i].valid, tbl[i].data);
      check("imem_we", i, {31'd0, imem_we}, {31'd0, tbl[i].we});
      check("imem_addr", i, imem_addr, tbl[i].addr);
      check("imem_wdata", i, imem_wdata, tbl[i].wdata);
      check("cpu_reset", i, {31'd0, cpu_reset}, {31'd0, tbl[i].cr});
      check("load_done", i, {31'd0, load_done}, {31'd0, tbl[i].done});
      check("load_error", i, {31'd0, load_error}, {31'd0, tbl[i].err});
      check("words_rx", i, {16'd0, words_rx}, {16'd0, tbl[i].words});
    end

    // Timeout latency measured directly: error appears 50 cycles after the last byte.
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'hA5);
    drive(1'b0, 1'b0, 1'b1, 8'h00);
    drive(1'b0, 1'b0, 1'b1, 8'h01);
    drive(1'b0, 1'b0, 1'b1, 8'hDE);
    drive(1'b0, 1'b0, 1'b1, 8'hAD);
    n = 0;
    while (!load_error && n < 200) begin
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      n++;
    end
    check("timeout_cycles", 0, 32'(n), 32'd50);
    check("timeout_cpu_reset", 0, {31'd0, cpu_reset}, 32'd1);
    check("timeout_done", 0, {31'd0, load_done}, 32'd0);
    check("timeout_words", 0, {16'd0, words_rx}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
